// File: rtl/gpu_decode_issue.sv
// Decode-and-issue stage: field split, control strobes, load scoreboard and registered output.
// Optional build macro GPU_DECODE_SCOREBOARD_EN enables the load scoreboard and hazard stalling.
module gpu_decode_issue #(
    parameter int REG_W = 4,
    parameter int IMM_W = 16,
    parameter int PC_W  = 16,
    localparam int NUM_REGS = 2**REG_W,
    localparam int INSTR_W  = 4 + 3*REG_W + IMM_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  in_instr,
    input  logic [PC_W-1:0]     in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [3:0]          out_opcode,
    output logic [REG_W-1:0]    out_rd,
    output logic [REG_W-1:0]    out_rs1,
    output logic [REG_W-1:0]    out_rs2,
    output logic [IMM_W-1:0]    out_imm,
    output logic [PC_W-1:0]     out_pc,
    output logic                out_we,
    output logic                out_mem_rd,
    output logic                out_mem_wr,
    output logic                out_branch,
    output logic                out_jump,
    output logic                out_illegal,
    input  logic                wb_valid,
    input  logic [REG_W-1:0]    wb_rd,
    output logic [NUM_REGS-1:0] busy_regs,
    output logic [7:0]          illegal_count
);
    localparam logic [3:0] OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_MOV = 4'd3,
                           OP_LDR = 4'd4, OP_STR = 4'd5, OP_BEQ = 4'd6, OP_JMP = 4'd7;

    typedef struct packed {
        logic [3:0]       opcode;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [IMM_W-1:0] imm;
        logic [PC_W-1:0]  pc;
        logic             we;
        logic             mem_rd;
        logic             mem_wr;
        logic             branch;
        logic             jump;
        logic             illegal;
    } dec_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    dec_t       dec_p0, dec_p1;
    logic       vld_p1;
    logic       use_rs1, use_rs2, hazard, accept;

    // Stage p0: combinational decode of the incoming word
    always_comb begin
        dec_p0         = '0;
        dec_p0.opcode  = in_instr[INSTR_W-1 -: 4];
        dec_p0.rd      = in_instr[INSTR_W-5 -: REG_W];
        dec_p0.rs1     = in_instr[INSTR_W-5-REG_W -: REG_W];
        dec_p0.rs2     = in_instr[IMM_W+REG_W-1 -: REG_W];
        dec_p0.imm     = in_instr[IMM_W-1:0];
        dec_p0.pc      = in_pc;
        use_rs1        = 1'b0;
        use_rs2        = 1'b0;
        case (dec_p0.opcode)
            OP_NOP: ;
            OP_ADD, OP_SUB: begin dec_p0.we = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_MOV: dec_p0.we = 1'b1;
            OP_LDR: begin dec_p0.we = 1'b1; dec_p0.mem_rd = 1'b1; use_rs1 = 1'b1; end
            OP_STR: begin dec_p0.mem_wr = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_BEQ: begin dec_p0.branch = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_JMP: dec_p0.jump = 1'b1;
            default: dec_p0.illegal = 1'b1;
        endcase
    end

`ifdef GPU_DECODE_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy_q, pend, wb_mask, set_mask;

    // A writeback landing this cycle bypasses its pending bit
    assign wb_mask  = NUM_REGS'(wb_valid) << wb_rd;
    assign pend     = busy_q & ~wb_mask;
    assign hazard   = (use_rs1 && pend[dec_p0.rs1]) || (use_rs2 && pend[dec_p0.rs2]) ||
                      (dec_p0.we && pend[dec_p0.rd]);
    assign set_mask = NUM_REGS'(accept && dec_p0.mem_rd) << dec_p0.rd;

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= (busy_q & ~wb_mask) | set_mask;
    end

    assign busy_regs = busy_q;
`else
    logic unused_sb;
    assign unused_sb = ^{wb_valid, wb_rd, use_rs1, use_rs2};
    assign hazard    = 1'b0;
    assign busy_regs = '0;
`endif

    assign in_ready = (!vld_p1 || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    // Stage p1: output register
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1        <= 1'b0;
            dec_p1        <= '0;
            illegal_count <= '0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
            dec_p1 <= dec_p0;
            if (dec_p0.illegal) illegal_count <= sat_inc(illegal_count);
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid   = vld_p1;
    assign out_opcode  = dec_p1.opcode;
    assign out_rd      = dec_p1.rd;
    assign out_rs1     = dec_p1.rs1;
    assign out_rs2     = dec_p1.rs2;
    assign out_imm     = dec_p1.imm;
    assign out_pc      = dec_p1.pc;
    assign out_we      = dec_p1.we;
    assign out_mem_rd  = dec_p1.mem_rd;
    assign out_mem_wr  = dec_p1.mem_wr;
    assign out_branch  = dec_p1.branch;
    assign out_jump    = dec_p1.jump;
    assign out_illegal = dec_p1.illegal;
endmodule

// File: tb/tb_gpu_decode_issue.sv
// Randomised plus directed bench for gpu_decode_issue against an instruction-level reference model.
// The model follows GPU_DECODE_SCOREBOARD_EN the same way the design build does.
module tb_gpu_decode_issue;
    localparam int REG_W = 4, IMM_W = 16, PC_W = 16, NUM_REGS = 16, INSTR_W = 32;
`ifdef GPU_DECODE_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [INSTR_W-1:0] in_instr = '0;
    logic [PC_W-1:0] in_pc = '0, out_pc;
    logic [3:0] out_opcode;
    logic [REG_W-1:0] out_rd, out_rs1, out_rs2, wb_rd = '0;
    logic [IMM_W-1:0] out_imm;
    logic out_we, out_mem_rd, out_mem_wr, out_branch, out_jump, out_illegal, wb_valid = 1'b0;
    logic [NUM_REGS-1:0] busy_regs;
    logic [7:0] illegal_count;

    gpu_decode_issue #(.REG_W(REG_W), .IMM_W(IMM_W), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm), .out_pc(out_pc),
        .out_we(out_we), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_branch(out_branch),
        .out_jump(out_jump), .out_illegal(out_illegal), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .busy_regs(busy_regs), .illegal_count(illegal_count));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: the held instruction, the set of pending load targets, the counter
    bit        m_valid;
    bit [31:0] m_instr;
    bit [15:0] m_pc;
    bit        m_pend[NUM_REGS];
    int        m_cnt;

    function automatic bit [31:0] mk(input int op, input int rd, input int rs1, input int rs2, input int imm);
        return {op[3:0], rd[3:0], rs1[3:0], rs2[3:0], imm[15:0]};
    endfunction

    // Returns {we, mem_rd, mem_wr, branch, jump, illegal, uses_rs1, uses_rs2}
    function automatic bit [7:0] ref_ctl(input bit [3:0] op);
        case (op)
            0: return 8'b000000_00;
            1, 2: return 8'b100000_11;
            3: return 8'b100000_00;
            4: return 8'b110000_10;
            5: return 8'b001000_11;
            6: return 8'b000100_11;
            7: return 8'b000010_00;
            default: return 8'b000001_00;
        endcase
    endfunction

    function automatic bit pending(input int r, input bit wv, input int wr);
        return SB_EN && m_pend[r] && !(wv && wr == r);
    endfunction

    function automatic bit ref_ready(input bit [31:0] ins, input bit ordy, input bit wv, input int wr);
        bit [7:0] c = ref_ctl(ins[31:28]);
        bit haz;
        haz = (c[1] && pending(ins[23:20], wv, wr)) || (c[0] && pending(ins[19:16], wv, wr)) ||
              (c[7] && pending(ins[27:24], wv, wr));
        return (!m_valid || ordy) && !haz;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_instr = 0; m_pc = 0; m_cnt = 0;
        foreach (m_pend[i]) m_pend[i] = 0;
    endtask

    task automatic check_outputs(input string tag);
        bit [7:0] c = ref_ctl(m_instr[31:28]);
        logic [15:0] pv;
        foreach (m_pend[i]) pv[i] = m_pend[i];
        chk({tag, ".out_valid"}, out_valid, m_valid);
        chk({tag, ".illegal_count"}, illegal_count, m_cnt);
        chk({tag, ".busy_regs"}, busy_regs, pv);
        if (m_valid) begin
            chk({tag, ".fields"}, {out_opcode, out_rd, out_rs1, out_rs2, out_imm}, m_instr);
            chk({tag, ".out_pc"}, out_pc, m_pc);
            chk({tag, ".strobes"}, {out_we, out_mem_rd, out_mem_wr, out_branch, out_jump, out_illegal},
                c[7:2]);
        end
    endtask

    // One cycle: drive at the falling edge, check, then advance the model across the rising edge
    task automatic step(input string tag, input bit v, input bit [31:0] ins, input bit [15:0] pc,
                        input bit ordy, input bit wv, input int wr);
        bit exp_rdy, acc;
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; wb_valid = wv; wb_rd = wr[3:0];
        #1;
        exp_rdy = ref_ready(ins, ordy, wv, wr);
        check_outputs(tag);
        chk({tag, ".in_ready"}, in_ready, exp_rdy);
        acc = v && exp_rdy;
        @(posedge clk);
        if (SB_EN) begin
            if (wv) m_pend[wr] = 0;
            if (acc && ins[31:28] == 4) m_pend[ins[27:24]] = 1;
        end
        if (acc) begin
            m_valid = 1; m_instr = ins; m_pc = pc;
            if (ins[31:28] >= 8 && m_cnt < 255) m_cnt++;
        end else if (ordy) m_valid = 0;
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1; in_valid = 0; wb_valid = 0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();
        chk("reset.fields", {out_opcode, out_rd, out_rs1, out_rs2, out_imm, out_pc}, 0);
        chk("reset.strobes", {out_we, out_mem_rd, out_mem_wr, out_branch, out_jump, out_illegal}, 0);
        step("reset", 0, 0, 0, 1, 0, 0);

        step("stream.add", 1, mk(1, 1, 2, 3, 0), 16'h0100, 1, 0, 0);
        step("stream.mov", 1, mk(3, 4, 0, 0, 16'h1234), 16'h0104, 1, 0, 0);
        chk("stream.mov_imm_next", in_ready, 1);
        step("stream.jmp", 1, mk(7, 0, 0, 0, 16'h0040), 16'h0108, 1, 0, 0);
        chk("stream.jmp_imm", out_imm, 16'h0040);
        idle("stream.drain", 2);

        step("raw.ldr", 1, mk(4, 5, 2, 0, 0), 16'h0200, 1, 0, 0);
        for (int i = 0; i < 3; i++) step("raw.add_wait", 1, mk(1, 6, 5, 1, 0), 16'h0204, 1, 0, 0);
        step("raw.add_wb", 1, mk(1, 6, 5, 1, 0), 16'h0204, 1, 1, 5);
        chk("raw.busy5_clear", busy_regs[5], 0);
        idle("raw.drain", 2);

        step("waw.ldr1", 1, mk(4, 7, 1, 0, 0), 16'h0300, 1, 0, 0);
        for (int i = 0; i < 3; i++) step("waw.ldr2_wait", 1, mk(4, 7, 2, 0, 0), 16'h0304, 1, 0, 0);
        step("waw.mov_wait", 1, mk(3, 7, 0, 0, 5), 16'h0308, 1, 0, 0);
        step("waw.ldr2_wb", 1, mk(4, 7, 2, 0, 0), 16'h0304, 1, 1, 7);
        step("waw.mov_wait2", 1, mk(3, 7, 0, 0, 5), 16'h0308, 1, 0, 0);
        step("waw.wb", 0, 0, 0, 1, 1, 7);
        idle("waw.drain", 2);

        for (int i = 0; i < 300; i++)
            step("illegal", 1, mk(10, $urandom_range(15), $urandom_range(15), $urandom_range(15),
                 $urandom_range(16'hFFFF)), 16'(i), 1, 0, 0);
        idle("illegal.drain", 1);
        chk("illegal.saturated", illegal_count, 255);

        step("bp.first", 1, mk(2, 3, 1, 2, 16'hBEEF), 16'h0400, 1, 0, 0);
        for (int i = 0; i < 5; i++) step("bp.hold", 1, mk(6, 0, 4, 5, 16'h0010), 16'h0404, 0, 0, 0);
        step("bp.release", 1, mk(6, 0, 4, 5, 16'h0010), 16'h0404, 1, 0, 0);
        step("bp.next", 1, mk(5, 0, 8, 9, 16'h0020), 16'h0408, 1, 0, 0);
        idle("bp.drain", 1);

        step("rst.ldr", 1, mk(4, 9, 0, 0, 0), 16'h0500, 0, 0, 0);
        step("rst.ill", 0, 0, 0, 0, 0, 0);
        do_reset();
        step("rst.after", 0, 0, 0, 1, 0, 0);
        step("rst.stale_wb", 0, 0, 0, 1, 1, 9);
        step("rst.ldr_add.ldr", 1, mk(4, 5, 2, 0, 0), 16'h0600, 1, 0, 0);
        step("rst.ldr_add.add", 1, mk(1, 6, 5, 1, 0), 16'h0604, 1, 0, 0);
        step("rst.ldr_add.wb", 1, mk(1, 6, 5, 1, 0), 16'h0604, 1, 1, 5);
        idle("rst.drain", 2);

        for (int i = 0; i < 3000; i++) begin
            int op = ($urandom_range(3) == 0) ? $urandom_range(15) : $urandom_range(7);
            int wr = $urandom_range(3);
            step("rand", $urandom_range(3) != 0,
                 mk(op, $urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(16'hFFFF)),
                 16'($urandom_range(16'hFFFF)), $urandom_range(3) != 0, $urandom_range(2) == 0, wr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
